// File: rtl/pkt_stream_pkg.sv
// rtl/pkt_stream_pkg.sv - shared types and constants for the packet stream
// Shared by the sink and, later, the generator.
package pkt_stream_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam logic [CTRL_W-1:0] CTRL_NONE = 8'h00;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  function automatic logic is_delim(input logic [CTRL_W-1:0] ctrl);
    return ctrl != CTRL_NONE;
  endfunction

endpackage

// File: rtl/pkt_stream_sink_if.sv
// rtl/pkt_stream_sink_if.sv - stream, read-port and status signals of the sink
// master = upstream/reader side, slave = pkt_stream_sink.
interface pkt_stream_sink_if #(
  parameter int LEN_W = 8
);
  import pkt_stream_pkg::*;

  logic              in_wr;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_empty;
  logic              pkt_done;
  logic [LEN_W-1:0]  pkt_len;
  logic [DATA_W-1:0] pkt_xsum;
  logic              err_ovf;

  modport master (
    output in_wr, in_ctrl, in_data, rd_en,
    input  in_rdy, rd_data, rd_valid, rd_empty, pkt_done, pkt_len, pkt_xsum, err_ovf
  );

  modport slave (
    input  in_wr, in_ctrl, in_data, rd_en,
    output in_rdy, rd_data, rd_valid, rd_empty, pkt_done, pkt_len, pkt_xsum, err_ovf
  );

endinterface

// File: rtl/pkt_sync_fifo.sv
// rtl/pkt_sync_fifo.sv - DEPTH x WIDTH synchronous FIFO with registered read
// Push while full and pop while empty are ignored.
module pkt_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is not reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/pkt_stream_sink.sv
// rtl/pkt_stream_sink.sv - packet framing sink with payload buffer and per-packet stats
// Define PKT_SINK_XSUM_EN to build the payload XOR checksum; otherwise pkt_xsum is 0.
module pkt_stream_sink
  import pkt_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  pkt_stream_sink_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_in_rdy;
  logic              r_pkt_done;
  logic              r_err_ovf;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_pkt_len;

  logic              w_accept;
  logic              w_delim;
  logic              w_start;
  logic              w_end;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_full_next;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_count;

  assign w_accept = bus.in_wr && r_in_rdy;
  assign w_delim  = is_delim(bus.in_ctrl);
  assign w_start  = w_accept && w_delim && (r_state == IDLE);
  assign w_end    = w_accept && w_delim && (r_state == PAYLOAD);
  assign w_push   = w_accept && !w_delim && (r_state == PAYLOAD);
  // A payload word offered while not ready is lost but still counted.
  assign w_drop   = bus.in_wr && !r_in_rdy && !w_delim && (r_state == PAYLOAD);
  assign w_pop    = bus.rd_en && !w_fifo_empty;

  assign w_full_next = w_fifo_full || ((w_count == ALMOST_CNT) && w_push && !w_pop);

  pkt_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.in_data),
    .i_pop   (bus.rd_en),
    .o_data  (bus.rd_data),
    .o_valid (bus.rd_valid),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = PAYLOAD;
      PAYLOAD: if (w_end)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_rdy   <= 1'b0;
      r_pkt_done <= 1'b0;
      r_pkt_len  <= '0;
      r_len      <= '0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_rdy   <= !w_full_next;
      r_pkt_done <= w_end;
      if (w_start) begin
        r_len <= '0;
      end else if ((w_push || w_drop) && (r_len != '1)) begin
        r_len <= r_len + 1'b1;
      end
      if (w_end) begin
        r_pkt_len <= r_len;
      end
      if (w_drop) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

`ifdef PKT_SINK_XSUM_EN
  logic [DATA_W-1:0] r_xsum;
  logic [DATA_W-1:0] r_pkt_xsum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xsum     <= '0;
      r_pkt_xsum <= '0;
    end else begin
      if (w_start) begin
        r_xsum <= '0;
      end else if (w_push || w_drop) begin
        r_xsum <= r_xsum ^ bus.in_data;
      end
      if (w_end) begin
        r_pkt_xsum <= r_xsum;
      end
    end
  end

  assign bus.pkt_xsum = r_pkt_xsum;
`else
  assign bus.pkt_xsum = '0;
`endif

  assign bus.in_rdy   = r_in_rdy;
  assign bus.rd_empty = w_fifo_empty;
  assign bus.pkt_done = r_pkt_done;
  assign bus.pkt_len  = r_pkt_len;
  assign bus.err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_pkt_stream_sink.sv
// tb/tb_pkt_stream_sink.sv - directed bench for pkt_stream_sink at DEPTH 16 and DEPTH 4
// Both instances see the same stimulus; sel4 picks which one is observed.
module tb_pkt_stream_sink;
  import pkt_stream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tb_wr;
  logic [7:0]  tb_ctrl;
  logic [63:0] tb_data;
  logic        tb_rd_en;
  logic        sel4;

  int n_checks = 0;
  int n_fail   = 0;

  pkt_stream_sink_if #(.LEN_W(8)) if16 ();
  pkt_stream_sink_if #(.LEN_W(8)) if4 ();

  pkt_stream_sink #(.DEPTH(16), .LEN_W(8)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  pkt_stream_sink #(.DEPTH(4),  .LEN_W(8)) dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if16.in_wr   = tb_wr;
  assign if16.in_ctrl = tb_ctrl;
  assign if16.in_data = tb_data;
  assign if16.rd_en   = tb_rd_en;
  assign if4.in_wr    = tb_wr;
  assign if4.in_ctrl  = tb_ctrl;
  assign if4.in_data  = tb_data;
  assign if4.rd_en    = tb_rd_en;

  logic        o_rdy, o_valid, o_empty, o_done, o_err;
  logic [63:0] o_data, o_xsum;
  logic [7:0]  o_len;
  assign o_rdy   = sel4 ? if4.in_rdy   : if16.in_rdy;
  assign o_valid = sel4 ? if4.rd_valid : if16.rd_valid;
  assign o_empty = sel4 ? if4.rd_empty : if16.rd_empty;
  assign o_done  = sel4 ? if4.pkt_done : if16.pkt_done;
  assign o_err   = sel4 ? if4.err_ovf  : if16.err_ovf;
  assign o_data  = sel4 ? if4.rd_data  : if16.rd_data;
  assign o_xsum  = sel4 ? if4.pkt_xsum : if16.pkt_xsum;
  assign o_len   = sel4 ? if4.pkt_len  : if16.pkt_len;

  function automatic logic [63:0] xs(input logic [63:0] v);
`ifdef PKT_SINK_XSUM_EN
    return v;
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Generator-style write: waits for in_rdy, returns at the negedge after acceptance.
  task automatic send(input logic [7:0] c, input logic [63:0] d);
    int w = 0;
    tb_wr = 1'b0;
    while (!o_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("send_rdy", {63'd0, o_rdy}, 64'd1);
    tb_wr = 1'b1; tb_ctrl = c; tb_data = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic force_send(input logic [7:0] c, input logic [63:0] d);
    tb_wr = 1'b1; tb_ctrl = c; tb_data = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp);
    tb_rd_en = 1'b1;
    @(negedge clk);
    tb_rd_en = 1'b0;
    chk({tag, "_valid"}, {63'd0, o_valid}, 64'd1);
    chk(tag, o_data, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [63:0] w_bad, w_start, w_hello, w_hi, w_ok, acc;

  initial begin
    tb_wr = 1'b0; tb_ctrl = 8'h00; tb_data = 64'd0; tb_rd_en = 1'b0; sel4 = 1'b0;
    w_bad = "     bad"; w_start = "   start"; w_hello = "  Hello!";
    w_hi  = "Hi there"; w_ok = "     OK?";

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy",   {63'd0, o_rdy},   64'd0);
    chk("rst_empty", {63'd0, o_empty}, 64'd1);
    chk("rst_done",  {63'd0, o_done},  64'd0);
    chk("rst_len",   {56'd0, o_len},   64'd0);
    chk("rst_xsum",  o_xsum,           64'd0);
    chk("rst_err",   {63'd0, o_err},   64'd0);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_data",  o_data,           64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {63'd0, o_rdy}, 64'd1);

    // Basic packet, DEPTH 16
    send(8'h00, w_bad);
    send(8'h01, w_start);
    send(8'h00, w_hello);
    send(8'h00, w_hi);
    chk("basic_no_early_done", {63'd0, o_done}, 64'd0);
    send(8'h01, w_ok);
    chk("basic_done", {63'd0, o_done}, 64'd1);
    chk("basic_len",  {56'd0, o_len},  64'd2);
    chk("basic_xsum", o_xsum, xs(64'h2020_4865_6c6c_6f21 ^ 64'h4869_2074_6865_7265));
    @(negedge clk);
    chk("basic_done_pulse", {63'd0, o_done}, 64'd0);
    pop_chk("basic_pop0", w_hello);
    pop_chk("basic_pop1", w_hi);
    chk("basic_empty", {63'd0, o_empty}, 64'd1);
    @(negedge clk);
    chk("basic_valid_pulse", {63'd0, o_valid}, 64'd0);

    // Back-to-back generator passes, 10 payload words each
    for (int p = 0; p < 2; p++) begin
      send(8'h00, 64'hdead_0000 + 64'(p));
      send(8'h00, 64'hdead_0100 + 64'(p));
      send(8'h01, 64'h5354_4152_5400_0000);
      acc = 64'd0;
      for (int k = 0; k < 10; k++) begin
        send(8'h00, 64'h1000 * 64'(p + 1) + 64'(k));
        acc ^= 64'h1000 * 64'(p + 1) + 64'(k);
      end
      send(8'h02, 64'h454e_4400_0000_0000);
      chk("b2b_done", {63'd0, o_done}, 64'd1);
      chk("b2b_len",  {56'd0, o_len},  64'd10);
      chk("b2b_xsum", o_xsum, xs(acc));
      send(8'h00, 64'hbeef_0000);
      send(8'h00, 64'hbeef_0001);
      for (int k = 0; k < 10; k++) begin
        pop_chk("b2b_pop", 64'h1000 * 64'(p + 1) + 64'(k));
      end
      chk("b2b_empty", {63'd0, o_empty}, 64'd1);
    end

    // Backpressure, DEPTH 4, generator honours in_rdy
    sel4 = 1'b1;
    do_reset();
    send(8'h01, 64'h0);
    for (int k = 0; k < 4; k++) send(8'h00, 64'hA0 + 64'(k));
    chk("bp_rdy_low", {63'd0, o_rdy}, 64'd0);
    for (int k = 0; k < 4; k++) pop_chk("bp_pop", 64'hA0 + 64'(k));
    send(8'h00, 64'hA4);
    send(8'h00, 64'hA5);
    send(8'h01, 64'h0);
    chk("bp_len", {56'd0, o_len}, 64'd6);
    chk("bp_err", {63'd0, o_err}, 64'd0);
    pop_chk("bp_pop4", 64'hA4);
    pop_chk("bp_pop5", 64'hA5);

    // Forced overflow, DEPTH 4
    do_reset();
    send(8'h01, 64'h0);
    acc = 64'd0;
    for (int k = 0; k < 6; k++) begin
      force_send(8'h00, 64'hB0 + 64'(k));
      acc ^= 64'hB0 + 64'(k);
    end
    chk("ovf_err", {63'd0, o_err}, 64'd1);
    pop_chk("ovf_pop0", 64'hB0);
    send(8'h01, 64'h0);
    chk("ovf_done", {63'd0, o_done}, 64'd1);
    chk("ovf_len",  {56'd0, o_len},  64'd6);
    chk("ovf_xsum", o_xsum, xs(acc));
    pop_chk("ovf_pop1", 64'hB1);
    pop_chk("ovf_pop2", 64'hB2);
    pop_chk("ovf_pop3", 64'hB3);
    chk("ovf_empty", {63'd0, o_empty}, 64'd1);

    // Empty packet and read while empty
    send(8'h01, 64'h0);
    send(8'h01, 64'h0);
    chk("emp_done", {63'd0, o_done}, 64'd1);
    chk("emp_len",  {56'd0, o_len},  64'd0);
    chk("emp_xsum", o_xsum, 64'd0);
    tb_rd_en = 1'b1;
    @(negedge clk);
    tb_rd_en = 1'b0;
    chk("emp_rd_valid", {63'd0, o_valid}, 64'd0);
    chk("emp_rd_hold",  o_data, 64'hB3);
    chk("emp_err_sticky", {63'd0, o_err}, 64'd1);

    // Reset mid-packet, DEPTH 16
    sel4 = 1'b0;
    do_reset();
    send(8'h01, 64'h0);
    send(8'h00, 64'hC0);
    send(8'h01, 64'h0);
    chk("mid_pre_len", {56'd0, o_len}, 64'd1);
    send(8'h01, 64'h0);
    for (int k = 1; k < 4; k++) send(8'h00, 64'hC0 + 64'(k));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rdy",   {63'd0, o_rdy},   64'd0);
    chk("mid_empty", {63'd0, o_empty}, 64'd1);
    chk("mid_len",   {56'd0, o_len},   64'd0);
    chk("mid_data",  o_data,           64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done", {63'd0, o_done}, 64'd0);
    send(8'h01, 64'h0);
    send(8'h00, 64'hD0);
    send(8'h00, 64'hD1);
    send(8'h01, 64'h0);
    chk("mid_next_done", {63'd0, o_done}, 64'd1);
    chk("mid_next_len",  {56'd0, o_len},  64'd2);
    chk("mid_next_xsum", o_xsum, xs(64'hD0 ^ 64'hD1));
    pop_chk("mid_pop0", 64'hD0);
    pop_chk("mid_pop1", 64'hD1);
    chk("mid_end_empty", {63'd0, o_empty}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
